// File: rtl/display_scan_n.sv
// Time-multiplexed seven-segment driver: scans N_DIGITS shadowed hex nibbles onto one
// active-low segment bus. Optional feature macro: LEADING_ZERO_BLANK_EN.
module display_scan_n #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned DIG_W       = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  localparam int unsigned IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_DIGITS*DIG_W-1:0] num_all,
  input  logic                      load,
  input  logic                      en,
  output logic [6:0]                seg,
  output logic [N_DIGITS-1:0]       an,
  output logic [IDX_W-1:0]          digit_idx,
  output logic                      frame_done
);

  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] PreMax = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IdxMax = IDX_W'(N_DIGITS - 1);

  logic [PRE_W-1:0]          prescaler_q;
  logic [IDX_W-1:0]          idx_q;
  logic [N_DIGITS*DIG_W-1:0] shadow_q;
  logic                      tick;
  logic [DIG_W-1:0]          cur;
  logic                      blank;
  logic [6:0]                seg_d;
  logic [N_DIGITS-1:0]       an_d;
`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0]          lead;
`endif

  assign tick = (prescaler_q == PreMax);

  function automatic logic [6:0] enc(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    cur = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) cur = shadow_q[k*DIG_W +: DIG_W];
    end
    // Any bit above the low nibble blanks the digit.
    blank = ((cur >> 4) != '0);
`ifdef LEADING_ZERO_BLANK_EN
    lead = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (shadow_q[k*DIG_W +: DIG_W] != '0) lead = IDX_W'(k);
    end
    if (idx_q > lead) blank = 1'b1;
`endif
    seg_d = blank ? 7'h7F : enc(cur[3:0]);
    for (int k = 0; k < N_DIGITS; k++) begin
      an_d[k] = (idx_q != IDX_W'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      seg         <= 7'h7F;
      an          <= '1;
      digit_idx   <= '0;
      frame_done  <= 1'b0;
    end else begin
      prescaler_q <= tick ? '0 : prescaler_q + 1'b1;
      if (tick) idx_q <= (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
      frame_done <= tick && (idx_q == IdxMax);
      if (load) shadow_q <= num_all;
      // Enable gates only the outputs; the scan keeps its phase.
      seg       <= en ? seg_d : 7'h7F;
      an        <= en ? an_d : '1;
      digit_idx <= idx_q;
    end
  end

endmodule

// File: tb/tb_display_scan_n.sv
// Scoreboard bench for display_scan_n (4 digits, 4-bit, divide-by-4 refresh).
module tb_display_scan_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        en = 1'b0;
  logic [15:0] num_all = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;

  always #5 clk = ~clk;

  display_scan_n #(
    .N_DIGITS   (4),
    .DIG_W      (4),
    .REFRESH_DIV(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .num_all   (num_all),
    .load      (load),
    .en        (en),
    .seg       (seg),
    .an        (an),
    .digit_idx (digit_idx),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] didx;
    logic       fd;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          fd_cnt = 0;
  int          m_pre = 0;
  int          m_idx = 0;
  logic [15:0] m_shadow = '0;
  logic [6:0]  seen[4];
  logic [6:0]  enc_tbl[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t predict(input logic r, input logic e);
    exp_t x;
    int   lead;
    logic [3:0] d;
    x.seg = 7'h7F;
    x.an = 4'hF;
    x.didx = 2'd0;
    x.fd = 1'b0;
    if (!r) begin
      d = m_shadow[m_idx*4 +: 4];
      lead = 0;
      for (int k = 0; k < 4; k++) if (m_shadow[k*4 +: 4] != 4'h0) lead = k;
      if (e) begin
        x.an = ~(4'b0001 << m_idx);
        x.seg = enc_tbl[d];
`ifdef LEADING_ZERO_BLANK_EN
        if (m_idx > lead) x.seg = 7'h7F;
`endif
      end
      x.didx = 2'(m_idx);
      x.fd = (m_pre == 3) && (m_idx == 3);
    end
    return x;
  endfunction

  task automatic step(input logic r, input logic l, input logic e, input logic [15:0] n);
    exp_t want;
    rst = r;
    load = l;
    en = e;
    num_all = n;
    exp_q.push_back(predict(r, e));
    if (r) begin
      m_pre = 0;
      m_idx = 0;
      m_shadow = '0;
    end else begin
      if (l) m_shadow = n;
      if (m_pre == 3) begin
        m_pre = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_pre++;
      end
    end
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check_eq("seg", 16'(seg), 16'(want.seg));
    check_eq("an", 16'(an), 16'(want.an));
    check_eq("digit_idx", 16'(digit_idx), 16'(want.didx));
    check_eq("frame_done", 16'(frame_done), 16'(want.fd));
    if (frame_done === 1'b1) fd_cnt++;
    for (int k = 0; k < 4; k++) if (e && !r && an === ~(4'b0001 << k)) seen[k] = seg;
  endtask

  task automatic clear_seen();
    for (int k = 0; k < 4; k++) seen[k] = 7'hxx;
  endtask

  task automatic check_seen(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                            input logic [6:0] d1, input logic [6:0] d0);
    check_eq({tag, "_d0"}, 16'(seen[0]), 16'(d0));
    check_eq({tag, "_d1"}, 16'(seen[1]), 16'(d1));
    check_eq({tag, "_d2"}, 16'(seen[2]), 16'(d2));
    check_eq({tag, "_d3"}, 16'(seen[3]), 16'(d3));
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b0, 1'b1, 16'h0);

    fd_cnt = 0;
    repeat (32) step(1'b0, 1'b0, 1'b1, 16'h0);
    check_eq("frame_done_per_32", 16'(fd_cnt), 16'd2);

    step(1'b0, 1'b1, 1'b1, 16'h3A0F);
    clear_seen();
    repeat (20) step(1'b0, 1'b0, 1'b1, 16'h0);
    check_seen("load_3a0f", 7'h30, 7'h08, 7'h40, 7'h0E);

    for (int i = 0; i < 16 && m_idx != 2; i++) step(1'b0, 1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b1, 1'b1, 16'h1234);
    clear_seen();
    repeat (20) step(1'b0, 1'b0, 1'b1, 16'h0);
    check_seen("reload_1234", 7'h79, 7'h24, 7'h30, 7'h19);

    repeat (6) step(1'b0, 1'b0, 1'b1, 16'h0);
    repeat (10) step(1'b0, 1'b0, 1'b0, 16'h0);
    repeat (8) step(1'b0, 1'b0, 1'b1, 16'h0);

    step(1'b0, 1'b1, 1'b1, 16'hFFFF);
    for (int i = 0; i < 16 && m_idx != 3; i++) step(1'b0, 1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b0, 1'b1, 16'h0);
    step(1'b1, 1'b1, 1'b1, 16'hFFFF);
    clear_seen();
    repeat (20) step(1'b0, 1'b0, 1'b1, 16'h0);
`ifdef LEADING_ZERO_BLANK_EN
    check_seen("after_rst", 7'h7F, 7'h7F, 7'h7F, 7'h40);
    step(1'b0, 1'b1, 1'b1, 16'h0050);
    clear_seen();
    repeat (20) step(1'b0, 1'b0, 1'b1, 16'h0);
    check_seen("lzb_0050", 7'h7F, 7'h7F, 7'h12, 7'h40);
`else
    check_seen("after_rst", 7'h40, 7'h40, 7'h40, 7'h40);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
